tx_interrupt_ack_ctrl: RTL and testbench
========================================

# tx_interrupt_ack_ctrl

Interrupt-side companion to the tx interrupt source selector: captures tx-path event pulses into sticky pending bits, coalesces them, and drives a level interrupt to the PS until software acknowledges via write-1-to-clear. It sits in tx_intf between the event sources (tlast, phy_tx_start, accelerator start/end, try-complete, high_tx_allowed0..2) and the PS interrupt input, with its controls and status mapped onto the AXI-Lite slave registers.

## Interface
- NUM_SRC, 8, number of event sources
- CNT_WIDTH, 8, width of the coalescing event counter
- HOLDOFF_WIDTH, 16, width of the coalescing timeout counter

- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- src_evt  in  NUM_SRC  raw event levels: bit0 s00_axis_tlast, 1 phy_tx_start, 2 tx_start_from_acc, 3 tx_end_from_acc, 4 tx_try_complete, 5..7 high_tx_allowed0..2
- irq_mask  in  NUM_SRC  1 = source may raise the interrupt
- ack_valid  in  1  one-cycle software write strobe
- ack_bits  in  NUM_SRC  write-1-to-clear bits, qualified by ack_valid
- coalesce_num  in  CNT_WIDTH  masked events required before asserting; 0 or 1 = immediate
- holdoff_cycles  in  HOLDOFF_WIDTH  timeout from first masked event; 0 = immediate
- pending  out  NUM_SRC  sticky per-source pending status
- overflow  out  NUM_SRC  sticky: edge arrived while pending already set
- evt_cnt  out  CNT_WIDTH  masked edges accepted since last return to IDLE
- tx_itrpt  out  1  level interrupt to PS

## Operation
- Edge detect: src_d is a registered copy of src_evt; edge[i] = src_evt[i] & ~src_d[i]. A level held high produces one edge.
- pending[i] is set on edge[i] regardless of mask and cleared when ack_valid & ack_bits[i]. Same-cycle set and clear: set wins.
- overflow[i] is set on edge[i] when pending[i] = 1 and bit i is not being acked that cycle; cleared by the same ack as pending.
- evt_cnt increments by popcount(edge & irq_mask), saturates at 2^CNT_WIDTH-1, and is cleared on entry to IDLE.
- hot = |(pending & irq_mask), evaluated on next-cycle values.
- FSM states:
  - IDLE: on any masked edge, go to ASSERT if coalesce_num ≤ 1, holdoff_cycles = 0, or the edge popcount ≥ coalesce_num; otherwise go to COLLECT and load the holdoff counter with holdoff_cycles.
  - COLLECT: go to ASSERT when evt_cnt (updated) ≥ coalesce_num or the holdoff counter reaches 1. The holdoff counter decrements each cycle. Go to IDLE if hot falls to 0 through ack or mask change.
  - ASSERT: tx_itrpt = 1. Go to IDLE when hot = 0.
- Mask change: unmasking an already-pending source while in IDLE goes straight to ASSERT. Masking all pending sources in ASSERT returns to IDLE.

## Timing
- Reset values: pending = 0, overflow = 0, evt_cnt = 0, tx_itrpt = 0, src_d = 0, state = IDLE, holdoff counter = 0.
- Consequence of src_d reset to 0: a source already high when reset is released produces one edge on the first clock.
- All outputs are registered. An edge seen at cycle t updates pending and evt_cnt at t+1.
- Immediate mode: tx_itrpt rises at t+1.
- Timeout: tx_itrpt rises exactly holdoff_cycles cycles after the first masked edge's pending update, unless the count threshold is reached earlier.
- Deassert: an ack at cycle a that clears the last hot bit drops tx_itrpt at a+1, and the FSM returns to IDLE.
- Ack coinciding with a new masked edge on another source: tx_itrpt stays high with no gap.
- Asynchronous reset mid-operation forces all reset values immediately. No pending state survives reset.

## Configuration
- TX_ITRPT_OVERFLOW_EN defined: overflow tracking is implemented as described.
- Not defined: the overflow output is tied to 0 and its registers are removed. All other behaviour is identical.

## Structure
- Shared package tx_itrpt_pkg holds:
  - the state enum (IDLE, COLLECT, ASSERT),
  - source index constants (SRC_TLAST = 0 … SRC_HIGH_ALLOWED2 = 7),
  - the default widths.
- One sub-module, tx_itrpt_edge_det: a NUM_SRC-wide register plus rising-edge detect. The FSM, counters and sticky registers stay in the top module.

## Test plan
- mask = 0x01, coalesce_num = 0, edge on bit0 at t: pending = 0x01 and tx_itrpt = 1 at t+1; ack_bits = 0x01 at a gives tx_itrpt = 0 at a+1.
- coalesce_num = 3, holdoff_cycles = 100, mask = 0xFF, edges on bits 1, 2, 3 in separate cycles: tx_itrpt rises the cycle after the third edge; evt_cnt = 3.
- coalesce_num = 5, holdoff_cycles = 10, one edge on bit4: tx_itrpt rises exactly 10 cycles after pending = 0x10.
- pending = 0x02, second edge on bit1: overflow = 0x02 with the macro, 0 without. Ack 0x02 in the same cycle as an edge on bit1: pending stays 0x02 and overflow is not set.
- ASSERT with pending = 0x06, ack 0x02 while a new edge on bit5 arrives: tx_itrpt stays 1 and pending = 0x24.
- Reset asserted while in COLLECT with evt_cnt = 2: all outputs 0 immediately. src_evt held high through release gives exactly one edge.

Source files
------------

// File: rtl/tx_itrpt_pkg.sv
// Shared types and constants for the tx interrupt acknowledge controller.
package tx_itrpt_pkg;

    localparam int unsigned NUM_SRC_DEF       = 8;
    localparam int unsigned CNT_WIDTH_DEF     = 8;
    localparam int unsigned HOLDOFF_WIDTH_DEF = 16;

    localparam int unsigned SRC_TLAST         = 0;
    localparam int unsigned SRC_PHY_TX_START  = 1;
    localparam int unsigned SRC_ACC_START     = 2;
    localparam int unsigned SRC_ACC_END       = 3;
    localparam int unsigned SRC_TRY_COMPLETE  = 4;
    localparam int unsigned SRC_HIGH_ALLOWED0 = 5;
    localparam int unsigned SRC_HIGH_ALLOWED1 = 6;
    localparam int unsigned SRC_HIGH_ALLOWED2 = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ASSERT  = 2'd2
    } state_e;

endpackage

// File: rtl/tx_interrupt_ack_ctrl_if.sv
// Control/status bundle between tx event sources, AXI-Lite registers and the
// interrupt controller. master = register/source side, slave = controller.
interface tx_interrupt_ack_ctrl_if
    import tx_itrpt_pkg::*;
#(
    parameter int unsigned NUM_SRC       = NUM_SRC_DEF,
    parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter int unsigned HOLDOFF_WIDTH = HOLDOFF_WIDTH_DEF
) ();

    logic [NUM_SRC-1:0]       src_evt;
    logic [NUM_SRC-1:0]       irq_mask;
    logic                     ack_valid;
    logic [NUM_SRC-1:0]       ack_bits;
    logic [CNT_WIDTH-1:0]     coalesce_num;
    logic [HOLDOFF_WIDTH-1:0] holdoff_cycles;
    logic [NUM_SRC-1:0]       pending;
    logic [NUM_SRC-1:0]       overflow;
    logic [CNT_WIDTH-1:0]     evt_cnt;
    logic                     tx_itrpt;

    modport master (
        output src_evt, irq_mask, ack_valid, ack_bits, coalesce_num, holdoff_cycles,
        input  pending, overflow, evt_cnt, tx_itrpt
    );

    modport slave (
        input  src_evt, irq_mask, ack_valid, ack_bits, coalesce_num, holdoff_cycles,
        output pending, overflow, evt_cnt, tx_itrpt
    );

endinterface

// File: rtl/tx_itrpt_edge_det.sv
// Registered copy of the event levels plus rising-edge detect; a level held
// high yields a single edge, and a level high at reset release yields one too.
module tx_itrpt_edge_det #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] evt_i,
    output logic [W-1:0] edge_o
);

    logic [W-1:0] src_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_d_q <= '0;
        end else begin
            src_d_q <= evt_i;
        end
    end

    assign edge_o = evt_i & ~src_d_q;

endmodule

// File: rtl/tx_interrupt_ack_ctrl.sv
// Sticky pending/overflow capture, event coalescing and W1C-acknowledged level
// interrupt. Optional overflow tracking: define TX_ITRPT_OVERFLOW_EN.
module tx_interrupt_ack_ctrl
    import tx_itrpt_pkg::*;
#(
    parameter int unsigned NUM_SRC       = NUM_SRC_DEF,
    parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter int unsigned HOLDOFF_WIDTH = HOLDOFF_WIDTH_DEF
) (
    input  logic                   s00_axi_aclk,
    input  logic                   s00_axi_aresetn,
    tx_interrupt_ack_ctrl_if.slave bus
);

    localparam int unsigned SUMW = CNT_WIDTH + 1;

    state_e                   state_q;
    logic [HOLDOFF_WIDTH-1:0] hold_q;
    logic [CNT_WIDTH-1:0]     evt_cnt_q, evt_cnt_d;
    logic [NUM_SRC-1:0]       pending_q, pending_d;
    logic                     tx_itrpt_q;

    logic [NUM_SRC-1:0] evt_edge;
    logic [NUM_SRC-1:0] masked_edge;
    logic [NUM_SRC-1:0] ack_mask;
    logic [SUMW-1:0]    pop;
    logic [SUMW-1:0]    sum;
    logic               hot;
    logic               immediate;
    logic               cnt_reached;

    tx_itrpt_edge_det #(.W(NUM_SRC)) u_edge_det (
        .clk    (s00_axi_aclk),
        .rst_n  (s00_axi_aresetn),
        .evt_i  (bus.src_evt),
        .edge_o (evt_edge)
    );

    always_comb begin
        masked_edge = evt_edge & bus.irq_mask;
        ack_mask    = bus.ack_valid ? bus.ack_bits : '0;
        // set wins over a same-cycle clear
        pending_d   = (pending_q & ~ack_mask) | evt_edge;
        hot         = |(pending_d & bus.irq_mask);
        pop = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pop = pop + SUMW'(masked_edge[i]);
        end
        sum         = {1'b0, evt_cnt_q} + pop;
        evt_cnt_d   = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        immediate   = (bus.coalesce_num <= CNT_WIDTH'(1)) ||
                      (bus.holdoff_cycles == '0) ||
                      (pop >= {1'b0, bus.coalesce_num});
        cnt_reached = evt_cnt_d >= bus.coalesce_num;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            evt_cnt_q  <= '0;
            pending_q  <= '0;
            tx_itrpt_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            evt_cnt_q <= evt_cnt_d;
            case (state_q)
                IDLE: begin
                    if (|masked_edge) begin
                        if (immediate) begin
                            state_q    <= ASSERT;
                            tx_itrpt_q <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                            hold_q  <= bus.holdoff_cycles;
                        end
                    end else if (hot) begin
                        state_q    <= ASSERT;
                        tx_itrpt_q <= 1'b1;
                    end
                end
                COLLECT: begin
                    hold_q <= hold_q - HOLDOFF_WIDTH'(1);
                    if (!hot) begin
                        state_q   <= IDLE;
                        evt_cnt_q <= '0;
                    end else if (cnt_reached || (hold_q <= HOLDOFF_WIDTH'(1))) begin
                        state_q    <= ASSERT;
                        tx_itrpt_q <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (!hot) begin
                        state_q    <= IDLE;
                        tx_itrpt_q <= 1'b0;
                        evt_cnt_q  <= '0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_itrpt_q <= 1'b0;
                    evt_cnt_q  <= '0;
                end
            endcase
        end
    end

`ifdef TX_ITRPT_OVERFLOW_EN
    logic [NUM_SRC-1:0] overflow_q, overflow_d;

    always_comb begin
        overflow_d = (overflow_q & ~ack_mask) | (evt_edge & pending_q & ~ack_mask);
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = '0;
`endif

    assign bus.pending  = pending_q;
    assign bus.evt_cnt  = evt_cnt_q;
    assign bus.tx_itrpt = tx_itrpt_q;

endmodule

// File: tb/tb_tx_interrupt_ack_ctrl.sv
// Directed self-checking bench for tx_interrupt_ack_ctrl (honours TX_ITRPT_OVERFLOW_EN).
module tb_tx_interrupt_ack_ctrl;
    import tx_itrpt_pkg::*;

`ifdef TX_ITRPT_OVERFLOW_EN
    localparam logic [7:0] OVF_BIT1 = 8'h02;
`else
    localparam logic [7:0] OVF_BIT1 = 8'h00;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    tx_interrupt_ack_ctrl_if #(.NUM_SRC(8), .CNT_WIDTH(8), .HOLDOFF_WIDTH(16)) bus ();

    tx_interrupt_ack_ctrl #(.NUM_SRC(8), .CNT_WIDTH(8), .HOLDOFF_WIDTH(16)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .bus             (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] bits);
        bus.src_evt = bits;
        tick();
        bus.src_evt = 8'h00;
    endtask

    task automatic ack(input logic [7:0] bits);
        bus.ack_valid = 1'b1;
        bus.ack_bits  = bits;
        tick();
        bus.ack_valid = 1'b0;
        bus.ack_bits  = 8'h00;
    endtask

    task automatic cfg(input logic [7:0] mask, input logic [7:0] num, input logic [15:0] hold);
        bus.irq_mask       = mask;
        bus.coalesce_num   = num;
        bus.holdoff_cycles = hold;
    endtask

    task automatic test_reset();
        bus.src_evt = 8'h00; bus.ack_valid = 1'b0; bus.ack_bits = 8'h00;
        cfg(8'h00, 8'd0, 16'd0);
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rst_pending: got %h want 00", bus.pending); end
        checks++; if (bus.overflow !== 8'h00) begin errors++; $display("FAIL rst_overflow: got %h want 00", bus.overflow); end
        checks++; if (bus.evt_cnt !== 8'd0) begin errors++; $display("FAIL rst_evt_cnt: got %0d want 0", bus.evt_cnt); end
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL rst_tx_itrpt: got %b want 0", bus.tx_itrpt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_immediate();
        cfg(8'h01, 8'd0, 16'd0);
        pulse(8'h01 << SRC_TLAST);
        checks++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL imm_pending: got %h want 01", bus.pending); end
        checks++; if (bus.tx_itrpt !== 1'b1) begin errors++; $display("FAIL imm_rise: got %b want 1", bus.tx_itrpt); end
        checks++; if (bus.evt_cnt !== 8'd1) begin errors++; $display("FAIL imm_evt_cnt: got %0d want 1", bus.evt_cnt); end
        tick();
        checks++; if (bus.tx_itrpt !== 1'b1) begin errors++; $display("FAIL imm_hold: got %b want 1", bus.tx_itrpt); end
        ack(8'h01);
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL imm_ack_drop: got %b want 0", bus.tx_itrpt); end
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL imm_ack_pending: got %h want 00", bus.pending); end
        checks++; if (bus.evt_cnt !== 8'd0) begin errors++; $display("FAIL imm_cnt_clear: got %0d want 0", bus.evt_cnt); end
    endtask

    task automatic test_coalesce();
        logic [7:0] want_cnt;
        cfg(8'hFF, 8'd3, 16'd100);
        for (int i = 1; i <= 3; i++) begin
            pulse(8'h01 << i);
            want_cnt = 8'(i);
            checks++; if (bus.evt_cnt !== want_cnt) begin errors++; $display("FAIL coal_cnt%0d: got %0d want %0d", i, bus.evt_cnt, want_cnt); end
            checks++; if (bus.tx_itrpt !== (i == 3)) begin errors++; $display("FAIL coal_tx%0d: got %b want %b", i, bus.tx_itrpt, (i == 3)); end
        end
        checks++; if (bus.pending !== 8'h0E) begin errors++; $display("FAIL coal_pending: got %h want 0e", bus.pending); end
        ack(8'h0E);
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL coal_ack: got %b want 0", bus.tx_itrpt); end
    endtask

    task automatic test_holdoff();
        cfg(8'hFF, 8'd5, 16'd10);
        pulse(8'h01 << SRC_TRY_COMPLETE);
        checks++; if (bus.pending !== 8'h10) begin errors++; $display("FAIL hold_pending: got %h want 10", bus.pending); end
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL hold_tx0: got %b want 0", bus.tx_itrpt); end
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++; if (bus.tx_itrpt !== (k == 10)) begin errors++; $display("FAIL hold_tx_c%0d: got %b want %b", k, bus.tx_itrpt, (k == 10)); end
        end
        checks++; if (bus.evt_cnt !== 8'd1) begin errors++; $display("FAIL hold_cnt: got %0d want 1", bus.evt_cnt); end
        ack(8'h10);
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL hold_ack: got %b want 0", bus.tx_itrpt); end
    endtask

    task automatic test_overflow();
        cfg(8'hFF, 8'd0, 16'd0);
        pulse(8'h02);
        checks++; if (bus.overflow !== 8'h00) begin errors++; $display("FAIL ovf_first: got %h want 00", bus.overflow); end
        tick();
        pulse(8'h02);
        checks++; if (bus.overflow !== OVF_BIT1) begin errors++; $display("FAIL ovf_second: got %h want %h", bus.overflow, OVF_BIT1); end
        checks++; if (bus.pending !== 8'h02) begin errors++; $display("FAIL ovf_pending: got %h want 02", bus.pending); end
        ack(8'h02);
        checks++; if (bus.overflow !== 8'h00) begin errors++; $display("FAIL ovf_ack: got %h want 00", bus.overflow); end
        pulse(8'h02);
        tick();
        bus.src_evt = 8'h02;
        ack(8'h02);
        bus.src_evt = 8'h00;
        checks++; if (bus.pending !== 8'h02) begin errors++; $display("FAIL ovf_setwins: got %h want 02", bus.pending); end
        checks++; if (bus.overflow !== 8'h00) begin errors++; $display("FAIL ovf_acked_edge: got %h want 00", bus.overflow); end
        ack(8'h02);
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL ovf_clean: got %b want 0", bus.tx_itrpt); end
    endtask

    task automatic test_back_to_back();
        cfg(8'hFF, 8'd0, 16'd0);
        pulse(8'h06);
        checks++; if (bus.tx_itrpt !== 1'b1) begin errors++; $display("FAIL b2b_rise: got %b want 1", bus.tx_itrpt); end
        tick();
        bus.src_evt = 8'h01 << SRC_HIGH_ALLOWED0;
        ack(8'h02);
        bus.src_evt = 8'h00;
        checks++; if (bus.tx_itrpt !== 1'b1) begin errors++; $display("FAIL b2b_nogap: got %b want 1", bus.tx_itrpt); end
        checks++; if (bus.pending !== 8'h24) begin errors++; $display("FAIL b2b_pending: got %h want 24", bus.pending); end
        ack(8'h24);
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b want 0", bus.tx_itrpt); end
    endtask

    task automatic test_mask_change();
        cfg(8'h00, 8'd0, 16'd0);
        pulse(8'h01);
        tick();
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL mask_off: got %b want 0", bus.tx_itrpt); end
        bus.irq_mask = 8'h01;
        tick();
        checks++; if (bus.tx_itrpt !== 1'b1) begin errors++; $display("FAIL mask_unmask: got %b want 1", bus.tx_itrpt); end
        bus.irq_mask = 8'h00;
        tick();
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL mask_remask: got %b want 0", bus.tx_itrpt); end
        checks++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL mask_pending: got %h want 01", bus.pending); end
        ack(8'h01);
    endtask

    task automatic test_reset_mid();
        cfg(8'hFF, 8'd5, 16'd100);
        pulse(8'h01);
        pulse(8'h02);
        checks++; if (bus.evt_cnt !== 8'd2) begin errors++; $display("FAIL rmid_pre_cnt: got %0d want 2", bus.evt_cnt); end
        bus.src_evt = 8'h01;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rmid_pending: got %h want 00", bus.pending); end
        checks++; if (bus.evt_cnt !== 8'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", bus.evt_cnt); end
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL rmid_tx: got %b want 0", bus.tx_itrpt); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL rmid_rel_pending: got %h want 01", bus.pending); end
        tick(); tick();
        checks++; if (bus.evt_cnt !== 8'd1) begin errors++; $display("FAIL rmid_one_edge: got %0d want 1", bus.evt_cnt); end
        checks++; if (bus.tx_itrpt !== 1'b0) begin errors++; $display("FAIL rmid_no_tx: got %b want 0", bus.tx_itrpt); end
        bus.src_evt = 8'h00;
        ack(8'h01);
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_coalesce();
        test_holdoff();
        test_overflow();
        test_back_to_back();
        test_mask_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
